multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning the width of the select outputs that drive the datapath 8:1 muxes.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits, meaning instruction opcode from the instruction register.
REQ-005 SHALL have port funct, input, 6 bits, meaning the R-type function field.
REQ-006 SHALL have port zero, input, 1 bit, meaning the ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit, meaning the memory access completes this cycle.
REQ-008 SHALL have port pc_en, output, 1 bit, meaning the PC register load enable.
REQ-009 SHALL have ports ir_write, mem_write, reg_write, i_or_d, reg_dst and alu_src_a, each output, 1 bit.
REQ-010 SHALL have ports alu_src_b, res_sel, pc_sel and alu_ctrl, each output, SEL_W bits, meaning the datapath mux selects and the ALU operation.
REQ-011 SHALL have port illegal_op, output, 1 bit, meaning a one-cycle pulse on an unknown opcode or funct.
REQ-012 SHALL have port state_o, output, 4 bits, meaning the current state, for debug.

Function
REQ-013 SHALL implement the Moore FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP, encoded 0-11.
REQ-014 SHALL hold in FETCH until mem_ready=1; in that same cycle it SHALL assert ir_write=1 and pc_en=1 (pc_sel=000, PC+4; alu_src_a=0; alu_src_b=001), then go to DECODE.
REQ-015 SHALL go from DECODE to MEMADR for LW 100011 or SW 101011, to EXEC for R-type 000000, to BRANCH for BEQ 000100, to ADDIEX for ADDI 001000, and to JUMP for J 000010.
REQ-016 SHALL, in DECODE with any other opcode, pulse illegal_op for one cycle and return to FETCH; no write enable SHALL assert.
REQ-017 SHALL go from MEMADR to MEMRD for LW and to MEMWR for SW, with alu_src_a=1 and alu_src_b=010.
REQ-018 SHALL hold in MEMRD with i_or_d=1 until mem_ready=1, then go to MEMWB.
REQ-019 SHALL hold in MEMWR with i_or_d=1 until mem_ready=1; mem_write SHALL be 1 only in the completing cycle, then the FSM returns to FETCH.
REQ-020 SHALL assert in MEMWB reg_write=1, reg_dst=0 and res_sel=001 (memory data), then go to FETCH.
REQ-021 SHALL, in EXEC, decode funct as follows: 100000 gives ADD 010, 100010 gives SUB 110, 100100 gives AND 000, 100101 gives OR 001, 101010 gives SLT 111; then go to ALUWB.
REQ-022 SHALL, on an unknown funct in EXEC, pulse illegal_op, use alu_ctrl=010, and return to FETCH without writeback.
REQ-023 SHALL assert in ALUWB reg_write=1, reg_dst=1 and res_sel=000 (ALU out), then go to FETCH.
REQ-024 SHALL use alu_ctrl=110 in BRANCH; pc_sel=001 and pc_en=zero (combinational); next state FETCH.
REQ-025 SHALL use alu_src_b=010 and alu_ctrl=010 in ADDIEX; ADDIWB SHALL use reg_write=1, reg_dst=0 and res_sel=000.
REQ-026 SHALL use pc_sel=010 and pc_en=1 in JUMP; next state FETCH.
REQ-027 SHALL drive every output not listed for a state to 0; unused select codes 011-111 SHALL never be driven.
REQ-028 SHALL make instruction latency in cycles, with mem_ready tied to 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3; each wait cycle adds 1.

Reset
REQ-029 SHALL, on rst_n=0, force the state to FETCH immediately, regardless of clk.
REQ-030 SHALL drive every output to 0 during reset, with state_o=0000.
REQ-031 SHALL allow reset during any wait state to abort the access; no write enable SHALL assert after rst_n falls.
REQ-032 SHALL begin in FETCH at the first rising clk edge after rst_n rises.

Structure
REQ-033 SHALL place the state encodings, opcode and funct constants, alu_ctrl codes, and res_sel/pc_sel/alu_src_b codes in the shared package mc_pkg.
REQ-034 SHALL place funct-to-alu_ctrl decoding in the combinational sub-module alu_decoder; the FSM stays in multicycle_ctrl.

Verification
REQ-035 SHALL verify LW (opcode 100011) with mem_ready=1: states 0,1,2,3,4, then 0; reg_write=1 with res_sel=001 only in cycle 5.
REQ-036 SHALL verify SW with mem_ready low for 3 cycles in MEMWR: the FSM holds in state 5; mem_write=1 for exactly one cycle when mem_ready=1.
REQ-037 SHALL verify BEQ with zero=1, then zero=0: pc_en=1 with pc_sel=001 in BRANCH for the first, pc_en=0 for the second.
REQ-038 SHALL verify R-type funct 101010: alu_ctrl=111 in EXEC; funct 111111 pulses illegal_op, gives no reg_write, and returns to FETCH.
REQ-039 SHALL verify opcode 111111 in DECODE: illegal_op high for 1 cycle, and the next state is FETCH.
REQ-040 SHALL verify rst_n asserted mid-MEMRD, between clock edges: state_o=0000 and all outputs 0 immediately; FETCH resumes after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller.
//   - state_e : FSM state encoding (also exported on state_o for debug)
//   - OP_*    : instruction opcodes recognised in DECODE
//   - FN_*    : R-type funct codes
//   - ALU_*   : ALU operation codes
//   - RES_*, PC_*, SRCB_* : datapath mux select codes
//   - ctrl_t  : bundle of every control output, built by the FSM each cycle
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;

    localparam logic [2:0] PC_PLUS4  = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;

    localparam logic [2:0] SRCB_REG  = 3'b000;
    localparam logic [2:0] SRCB_FOUR = 3'b001;
    localparam logic [2:0] SRCB_IMM  = 3'b010;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       alu_src_a;
        logic       illegal_op;
        logic [2:0] alu_src_b;
        logic [2:0] res_sel;
        logic [2:0] pc_sel;
        logic [2:0] alu_ctrl;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder.
//   funct_i    : R-type function field
//   alu_ctrl_o : ALU operation; falls back to ADD on an unknown funct
//   valid_o    : funct is one of the supported operations
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       valid_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit (Moore FSM with a few
// mem_ready/zero-qualified enables).
//   clk, rst_n          : clock, async active-low reset
//   opcode, funct       : instruction fields from the IR
//   zero                : ALU zero flag (branch decision)
//   mem_ready           : memory access completes this cycle
//   pc_en .. alu_src_a  : datapath enables / 1-bit selects
//   alu_src_b, res_sel,
//   pc_sel, alu_ctrl    : SEL_W-bit mux selects and ALU op
//   illegal_op          : one-cycle pulse on unknown opcode/funct
//   state_o             : current state, debug only
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             i_or_d,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [SEL_W-1:0] alu_src_b,
    output logic [SEL_W-1:0] res_sel,
    output logic [SEL_W-1:0] pc_sel,
    output logic [SEL_W-1:0] alu_ctrl,
    output logic             illegal_op,
    output logic [3:0]       state_o
);

    state_e     state_q, state_d;
    ctrl_t      ctl_c, ctl;
    logic [2:0] fn_alu;
    logic       fn_valid;

    alu_decoder u_alu_dec (
        .funct_i    (funct),
        .alu_ctrl_o (fn_alu),
        .valid_o    (fn_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        ctl_c   = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctl_c.alu_src_b = SRCB_FOUR;
                ctl_c.pc_sel    = PC_PLUS4;
                if (mem_ready) begin
                    ctl_c.ir_write = 1'b1;
                    ctl_c.pc_en    = 1'b1;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        ctl_c.illegal_op = 1'b1;
                        state_d          = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl_c.alu_src_a = 1'b1;
                ctl_c.alu_src_b = SRCB_IMM;
                // Only LW/SW reach here, so anything but LW is a store.
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl_c.i_or_d = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl_c.reg_write = 1'b1;
                ctl_c.res_sel   = RES_MEM;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctl_c.i_or_d = 1'b1;
                // Strobe the write only on the completing cycle.
                if (mem_ready) begin
                    ctl_c.mem_write = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_EXEC: begin
                ctl_c.alu_ctrl   = fn_alu;
                ctl_c.illegal_op = !fn_valid;
                state_d          = fn_valid ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                ctl_c.reg_write = 1'b1;
                ctl_c.reg_dst   = 1'b1;
                ctl_c.res_sel   = RES_ALU;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctl_c.alu_ctrl = ALU_SUB;
                ctl_c.pc_sel   = PC_BRANCH;
                ctl_c.pc_en    = zero;
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                ctl_c.alu_src_b = SRCB_IMM;
                ctl_c.alu_ctrl  = ALU_ADD;
                state_d         = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl_c.reg_write = 1'b1;
                ctl_c.res_sel   = RES_ALU;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctl_c.pc_sel = PC_JUMP;
                ctl_c.pc_en  = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // FETCH drives PC+4 selects and mem_ready-qualified enables, so the
    // outputs are gated by rst_n to read all-zero while reset is held.
    assign ctl = rst_n ? ctl_c : '0;

    assign pc_en      = ctl.pc_en;
    assign ir_write   = ctl.ir_write;
    assign mem_write  = ctl.mem_write;
    assign reg_write  = ctl.reg_write;
    assign i_or_d     = ctl.i_or_d;
    assign reg_dst    = ctl.reg_dst;
    assign alu_src_a  = ctl.alu_src_a;
    assign illegal_op = ctl.illegal_op;
    assign alu_src_b  = SEL_W'(ctl.alu_src_b);
    assign res_sel    = SEL_W'(ctl.res_sel);
    assign pc_sel     = SEL_W'(ctl.pc_sel);
    assign alu_ctrl   = SEL_W'(ctl.alu_ctrl);
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change just after each
// falling edge, and the whole output vector is compared 1ns later
// against a hand-built expectation.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst, alu_src_a, illegal_op;
    logic [2:0] alu_src_b, res_sel, pc_sel, alu_ctrl;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .i_or_d     (i_or_d),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .res_sel    (res_sel),
        .pc_sel     (pc_sel),
        .alu_ctrl   (alu_ctrl),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    // Flag bits of the expected vector, MSB first.
    localparam logic [7:0] F_PCEN = 8'h80;
    localparam logic [7:0] F_IRW  = 8'h40;
    localparam logic [7:0] F_MEMW = 8'h20;
    localparam logic [7:0] F_REGW = 8'h10;
    localparam logic [7:0] F_IORD = 8'h08;
    localparam logic [7:0] F_RDST = 8'h04;
    localparam logic [7:0] F_SRCA = 8'h02;
    localparam logic [7:0] F_ILL  = 8'h01;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BADOP = 6'b111111;

    logic [23:0] obs;
    assign obs = {pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst, alu_src_a, illegal_op,
                  alu_src_b, res_sel, pc_sel, alu_ctrl, state_o};

    function automatic logic [23:0] ev(input logic [3:0] st, input logic [7:0] fl,
                                       input logic [2:0] sb, input logic [2:0] rs,
                                       input logic [2:0] ps, input logic [2:0] al);
        return {fl, sb, rs, ps, al, st};
    endfunction

    task automatic chk(input string tag, input logic [23:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic z);
        @(negedge clk);
        opcode    = op;
        funct     = fn;
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    logic [23:0] v_idle, v_fetch, v_dec;
    logic [5:0]  fn_tab [4];
    logic [2:0]  al_tab [4];

    initial begin
        v_idle  = ev(4'd0, 8'h00, 3'd1, 3'd0, 3'd0, 3'd0);
        v_fetch = ev(4'd0, F_PCEN | F_IRW, 3'd1, 3'd0, 3'd0, 3'd0);
        v_dec   = ev(4'd1, 8'h00, 3'd0, 3'd0, 3'd0, 3'd0);
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
        al_tab  = '{3'b010, 3'b110, 3'b000, 3'b001};

        rst_n = 1'b0; opcode = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held: everything zero even though mem_ready is high.
        step(LW, 6'd0, 1'b1, 1'b0); chk("rst_0", 24'h0);
        step(LW, 6'd0, 1'b1, 1'b0); chk("rst_1", 24'h0);

        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        chk("fetch_idle", v_idle);
        step(LW, 6'd0, 1'b0, 1'b0); chk("fetch_hold", v_idle);

        // LW, no wait states: 0,1,2,3,4 then FETCH
        step(LW, 6'd0, 1'b1, 1'b0); chk("lw_fetch", v_fetch);
        step(LW, 6'd0, 1'b1, 1'b0); chk("lw_dec", v_dec);
        step(LW, 6'd0, 1'b1, 1'b0); chk("lw_memadr", ev(4'd2, F_SRCA, 3'd2, 3'd0, 3'd0, 3'd0));
        step(LW, 6'd0, 1'b1, 1'b0); chk("lw_memrd", ev(4'd3, F_IORD, 3'd0, 3'd0, 3'd0, 3'd0));
        step(LW, 6'd0, 1'b1, 1'b0); chk("lw_memwb", ev(4'd4, F_REGW, 3'd0, 3'd1, 3'd0, 3'd0));

        // SW with three wait cycles in MEMWR
        step(SW, 6'd0, 1'b1, 1'b0); chk("sw_fetch", v_fetch);
        step(SW, 6'd0, 1'b1, 1'b0); chk("sw_dec", v_dec);
        step(SW, 6'd0, 1'b1, 1'b0); chk("sw_memadr", ev(4'd2, F_SRCA, 3'd2, 3'd0, 3'd0, 3'd0));
        for (int i = 0; i < 3; i++) begin
            step(SW, 6'd0, 1'b0, 1'b0); chk("sw_wait", ev(4'd5, F_IORD, 3'd0, 3'd0, 3'd0, 3'd0));
        end
        step(SW, 6'd0, 1'b1, 1'b0); chk("sw_done", ev(4'd5, F_IORD | F_MEMW, 3'd0, 3'd0, 3'd0, 3'd0));

        // BEQ taken, then not taken
        step(BEQ, 6'd0, 1'b1, 1'b0); chk("beq1_fetch", v_fetch);
        step(BEQ, 6'd0, 1'b1, 1'b0); chk("beq1_dec", v_dec);
        step(BEQ, 6'd0, 1'b1, 1'b1); chk("beq_taken", ev(4'd8, F_PCEN, 3'd0, 3'd0, 3'd1, 3'd6));
        step(BEQ, 6'd0, 1'b1, 1'b0); chk("beq2_fetch", v_fetch);
        step(BEQ, 6'd0, 1'b1, 1'b0); chk("beq2_dec", v_dec);
        step(BEQ, 6'd0, 1'b1, 1'b0); chk("beq_not", ev(4'd8, 8'h00, 3'd0, 3'd0, 3'd1, 3'd6));

        // R-type SLT
        step(RT, 6'b101010, 1'b1, 1'b0); chk("slt_fetch", v_fetch);
        step(RT, 6'b101010, 1'b1, 1'b0); chk("slt_dec", v_dec);
        step(RT, 6'b101010, 1'b1, 1'b0); chk("slt_exec", ev(4'd6, 8'h00, 3'd0, 3'd0, 3'd0, 3'd7));
        step(RT, 6'b101010, 1'b1, 1'b0); chk("slt_aluwb", ev(4'd7, F_REGW | F_RDST, 3'd0, 3'd0, 3'd0, 3'd0));

        // Remaining funct codes, checked in EXEC
        for (int k = 0; k < 4; k++) begin
            step(RT, fn_tab[k], 1'b1, 1'b0); chk("rt_fetch", v_fetch);
            step(RT, fn_tab[k], 1'b1, 1'b0); chk("rt_dec", v_dec);
            step(RT, fn_tab[k], 1'b1, 1'b0); chk("rt_exec", ev(4'd6, 8'h00, 3'd0, 3'd0, 3'd0, al_tab[k]));
            step(RT, fn_tab[k], 1'b1, 1'b0); chk("rt_aluwb", ev(4'd7, F_REGW | F_RDST, 3'd0, 3'd0, 3'd0, 3'd0));
        end

        // Unknown funct: illegal pulse, ADD, straight back to FETCH
        step(RT, 6'b111111, 1'b1, 1'b0); chk("badfn_fetch", v_fetch);
        step(RT, 6'b111111, 1'b1, 1'b0); chk("badfn_dec", v_dec);
        step(RT, 6'b111111, 1'b1, 1'b0); chk("badfn_exec", ev(4'd6, F_ILL, 3'd0, 3'd0, 3'd0, 3'd2));
        step(ADDI, 6'd0, 1'b1, 1'b0);    chk("badfn_ret", v_fetch);

        // ADDI
        step(ADDI, 6'd0, 1'b1, 1'b0); chk("addi_dec", v_dec);
        step(ADDI, 6'd0, 1'b1, 1'b0); chk("addi_ex", ev(4'd9, 8'h00, 3'd2, 3'd0, 3'd0, 3'd2));
        step(ADDI, 6'd0, 1'b1, 1'b0); chk("addi_wb", ev(4'd10, F_REGW, 3'd0, 3'd0, 3'd0, 3'd0));

        // J
        step(J, 6'd0, 1'b1, 1'b0); chk("j_fetch", v_fetch);
        step(J, 6'd0, 1'b1, 1'b0); chk("j_dec", v_dec);
        step(J, 6'd0, 1'b1, 1'b0); chk("j_jump", ev(4'd11, F_PCEN, 3'd0, 3'd0, 3'd2, 3'd0));

        // Unknown opcode
        step(BADOP, 6'd0, 1'b1, 1'b0); chk("badop_fetch", v_fetch);
        step(BADOP, 6'd0, 1'b1, 1'b0); chk("badop_dec", ev(4'd1, F_ILL, 3'd0, 3'd0, 3'd0, 3'd0));
        step(BADOP, 6'd0, 1'b0, 1'b0); chk("badop_ret", v_idle);

        // Reset mid-MEMRD, asserted between edges
        step(LW, 6'd0, 1'b1, 1'b0); chk("rlw_fetch", v_fetch);
        step(LW, 6'd0, 1'b1, 1'b0); chk("rlw_dec", v_dec);
        step(LW, 6'd0, 1'b0, 1'b0); chk("rlw_memadr", ev(4'd2, F_SRCA, 3'd2, 3'd0, 3'd0, 3'd0));
        step(LW, 6'd0, 1'b0, 1'b0); chk("rlw_memrd", ev(4'd3, F_IORD, 3'd0, 3'd0, 3'd0, 3'd0));
        @(posedge clk); #2;
        rst_n = 1'b0; mem_ready = 1'b1; #1;
        chk("rst_async", 24'h0);
        @(negedge clk); #1; chk("rst_mid_hold", 24'h0);
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        chk("rst_release", v_idle);
        step(LW, 6'd0, 1'b1, 1'b0); chk("resume_fetch", v_fetch);
        step(LW, 6'd0, 1'b1, 1'b0); chk("resume_dec", v_dec);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
